// File: rtl/lsu_pkg.sv
// Encodings shared between the decoder and the load/store unit.
package lsu_pkg;

   typedef enum logic [1:0] {
      SZ_WORD = 2'b00,
      SZ_HALF = 2'b01,
      SZ_BYTE = 2'b10,
      SZ_BAD  = 2'b11
   } size_e;

   typedef enum logic [2:0] {
      LT_LB  = 3'b000,
      LT_LH  = 3'b001,
      LT_LW  = 3'b010,
      LT_LBU = 3'b100,
      LT_LHU = 3'b101
   } ltype_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BEAT1 = 2'd1,
      RESP  = 2'd2
   } state_e;

   typedef struct packed {
      logic        wr;
      size_e       size;
      logic [2:0]  ltype;
      logic [31:0] addr;
      logic [31:0] wdata;
   } req_t;

   function automatic logic [3:0] size_mask(input size_e s);
      case (s)
         SZ_BYTE: size_mask = 4'b0001;
         SZ_HALF: size_mask = 4'b0011;
         SZ_WORD: size_mask = 4'b1111;
         default: size_mask = 4'b0000;
      endcase
   endfunction

endpackage

// File: rtl/lsu_sram.sv
// DEPTH x 32 single-port RAM with byte enables; q registered one cycle after en.
// Read-during-write to the same word returns the old contents; no backpressure.
module lsu_sram #(
   parameter int DEPTH = 256,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          en,
   input  logic          we,
   input  logic [3:0]    be,
   input  logic [AW-1:0] idx,
   input  logic [31:0]   wdata,
   output logic [31:0]   q
);

   logic [31:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            for (int b = 0; b < 4; b++) begin
               if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
         end
         q <= mem[idx];
      end
   end

endmodule

// File: rtl/lsu_data_mem.sv
// Load/store responder over a word RAM; rsp 1 cycle after accept (2 when split), req_ready only in IDLE.
// MISALIGN_SPLIT_EN: word-crossing accesses become two beats instead of raising acc_err.
module lsu_data_mem
   import lsu_pkg::*;
#(
   parameter int DEPTH = 256
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   input  logic        d_wr_en,
   input  logic [1:0]  d_size,
   input  logic [2:0]  load_type,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        req_ready,
   output logic        rsp_valid,
   output logic [31:0] rdata,
   output logic        acc_err
);

   localparam int AW = $clog2(DEPTH);

   state_e          state, state_nxt;
   req_t            req_q, req_cur;
   logic            err_q, split_q;
   logic [31:0]     q_lo_q;
   logic [31:0]     ram_q;

   logic            illegal, crosses, err_now, split_now;
   size_e           acc_size;
   logic [1:0]      off;
   logic [7:0]      be64;
   logic [63:0]     wd64;
   logic            unused_addr_hi;

   logic            ram_en, ram_we;
   logic [3:0]      ram_be;
   logic [31:0]     ram_wdata;
   logic [AW-1:0]   ram_idx;

   logic [63:0]     merged;
   logic [31:0]     lane;

   // Live inputs while accepting, the latched request for the later beats.
   always_comb begin
      if (state == IDLE) begin
         req_cur = '{wr: d_wr_en, size: size_e'(d_size), ltype: load_type,
                     addr: addr, wdata: wdata};
      end else begin
         req_cur = req_q;
      end
   end

   assign unused_addr_hi = ^req_cur.addr[31:AW+2];

   always_comb begin
      illegal  = 1'b0;
      acc_size = SZ_WORD;
      if (req_cur.wr) begin
         acc_size = req_cur.size;
         illegal  = (req_cur.size == SZ_BAD);
      end else begin
         case (req_cur.ltype)
            LT_LB, LT_LBU: acc_size = SZ_BYTE;
            LT_LH, LT_LHU: acc_size = SZ_HALF;
            LT_LW:         acc_size = SZ_WORD;
            default:       illegal  = 1'b1;
         endcase
      end
      off     = req_cur.addr[1:0];
      crosses = ((acc_size == SZ_HALF) && (off == 2'b11)) ||
                ((acc_size == SZ_WORD) && (off != 2'b00));
`ifdef MISALIGN_SPLIT_EN
      split_now = !illegal && crosses;
      err_now   = illegal;
`else
      split_now = 1'b0;
      err_now   = illegal || crosses;
`endif
      // Lanes across the two-word window: low nibble/word is beat0, high is beat1.
      be64 = {4'b0000, size_mask(acc_size)} << off;
      wd64 = {req_cur.wdata, req_cur.wdata} << {off, 3'b000};
      if (acc_size == SZ_BYTE) wd64[31:0] = {4{req_cur.wdata[7:0]}};
   end

   always_comb begin
      state_nxt = state;
      ram_en    = 1'b0;
      ram_we    = req_cur.wr;
      ram_be    = be64[3:0];
      ram_wdata = wd64[31:0];
      ram_idx   = req_cur.addr[AW+1:2];
      case (state)
         IDLE: begin
            if (req_valid) begin
               ram_en    = !err_now;
               state_nxt = split_now ? BEAT1 : RESP;
            end
         end
         BEAT1: begin
            ram_en    = 1'b1;
            ram_be    = be64[7:4];
            ram_wdata = wd64[63:32];
            ram_idx   = req_cur.addr[AW+1:2] + AW'(1);
            state_nxt = RESP;
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      // A beat coinciding with reset is dropped, never half-written.
      if (!reset_n) ram_en = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state   <= IDLE;
         req_q   <= '0;
         err_q   <= 1'b0;
         split_q <= 1'b0;
         q_lo_q  <= '0;
      end else begin
         state <= state_nxt;
         if ((state == IDLE) && req_valid) begin
            req_q   <= req_cur;
            err_q   <= err_now;
            split_q <= split_now;
         end
         if (state == BEAT1) q_lo_q <= ram_q;
      end
   end

   lsu_sram #(.DEPTH(DEPTH), .AW(AW)) u_sram (
      .clk   (clk),
      .en    (ram_en),
      .we    (ram_we),
      .be    (ram_be),
      .idx   (ram_idx),
      .wdata (ram_wdata),
      .q     (ram_q)
   );

   assign req_ready = (state == IDLE);
   assign rsp_valid = (state == RESP);
   assign acc_err   = rsp_valid && err_q;

   always_comb begin
      merged = split_q ? {ram_q, q_lo_q} : {32'h0, ram_q};
      lane   = 32'(merged >> {req_q.addr[1:0], 3'b000});
      rdata  = '0;
      if (rsp_valid && !err_q && !req_q.wr) begin
         case (req_q.ltype)
            LT_LB:   rdata = {{24{lane[7]}}, lane[7:0]};
            LT_LH:   rdata = {{16{lane[15]}}, lane[15:0]};
            LT_LW:   rdata = lane;
            LT_LBU:  rdata = {24'h0, lane[7:0]};
            LT_LHU:  rdata = {16'h0, lane[15:0]};
            default: rdata = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_data_mem.sv
// Bench for lsu_data_mem: directed vector table, reset corner cases, and random traffic
// compared against a byte-array memory model.
module tb_lsu_data_mem;

   localparam int DEPTH  = 256;
   localparam int NBYTES = DEPTH * 4;
`ifdef MISALIGN_SPLIT_EN
   localparam bit SPLIT = 1'b1;
`else
   localparam bit SPLIT = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset_n;
   logic        req_valid;
   logic        d_wr_en;
   logic [1:0]  d_size;
   logic [2:0]  load_type;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        req_ready;
   logic        rsp_valid;
   logic [31:0] rdata;
   logic        acc_err;

   always #5 clk = ~clk;

   lsu_data_mem #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .req_valid (req_valid),
      .d_wr_en   (d_wr_en),
      .d_size    (d_size),
      .load_type (load_type),
      .addr      (addr),
      .wdata     (wdata),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rdata     (rdata),
      .acc_err   (acc_err)
   );

   typedef struct {
      logic        wr;
      logic [1:0]  sz;
      logic [2:0]  lt;
      logic [31:0] a;
      logic [31:0] wd;
      logic [31:0] rd;
      logic        err;
      int          lat;
   } vec_t;

   int          checks   = 0;
   int          failures = 0;
   byte unsigned mem_m [NBYTES];
   vec_t        tbl [$];
   logic [2:0]  lt_legal [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   function automatic int acc_bytes(input logic wr, input logic [1:0] sz, input logic [2:0] lt);
      if (wr) begin
         case (sz)
            2'b10:   return 1;
            2'b01:   return 2;
            2'b00:   return 4;
            default: return 0;
         endcase
      end
      case (lt)
         3'b000, 3'b100: return 1;
         3'b001, 3'b101: return 2;
         3'b010:         return 4;
         default:        return 0;
      endcase
   endfunction

   // Byte-addressed little-endian model; an access "splits" when it runs past its word.
   task automatic model(input logic wr, input logic [1:0] sz, input logic [2:0] lt,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic err, output int lat);
      int n    = acc_bytes(wr, sz, lt);
      int off  = int'(a[1:0]);
      int base = int'(a % NBYTES);
      rd  = '0;
      err = 1'b0;
      lat = 1;
      if (n == 0) begin
         err = 1'b1;
      end else if ((off + n > 4) && !SPLIT) begin
         err = 1'b1;
      end else begin
         if (off + n > 4) lat = 2;
         if (wr) begin
            for (int i = 0; i < n; i++) mem_m[(base + i) % NBYTES] = wd[8*i +: 8];
         end else begin
            for (int i = 0; i < n; i++) rd[8*i +: 8] = mem_m[(base + i) % NBYTES];
            if (!lt[2] && (n < 4) && rd[8*n-1]) rd = rd | (32'hFFFF_FFFF << (8*n));
         end
      end
   endtask

   // Issue one request from a negedge; returns at the negedge after the response.
   task automatic do_req(input string nm, input logic wr, input logic [1:0] sz, input logic [2:0] lt,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output logic err, output int lat);
      int waited = 0;
      while (!req_ready && waited < 4) begin
         @(negedge clk);
         waited++;
      end
      if (!req_ready) chk({nm, "_ready_timeout"}, 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      d_wr_en   = wr;
      d_size    = sz;
      load_type = lt;
      addr      = a;
      wdata     = wd;
      @(posedge clk);
      #1;
      req_valid = 1'($urandom);
      d_wr_en   = 1'($urandom);
      d_size    = 2'($urandom);
      load_type = 3'($urandom);
      addr      = $urandom;
      wdata     = $urandom;
      lat = 0;
      rd  = '0;
      err = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         if (rsp_valid) begin
            lat = c;
            rd  = rdata;
            err = acc_err;
            break;
         end
      end
      req_valid = 1'b0;
      if (lat == 0) chk({nm, "_rsp_timeout"}, 32'(rsp_valid), 32'd1);
      @(negedge clk);
      chk({nm, "_rsp_pulse"}, 32'(rsp_valid), 32'd0);
      chk({nm, "_ready_back"}, 32'(req_ready), 32'd1);
   endtask

   task automatic run_m(input string nm, input logic wr, input logic [1:0] sz, input logic [2:0] lt,
                        input logic [31:0] a, input logic [31:0] wd);
      logic [31:0] erd, ard;
      logic        eerr, aerr;
      int          elat, alat;
      model(wr, sz, lt, a, wd, erd, eerr, elat);
      do_req(nm, wr, sz, lt, a, wd, ard, aerr, alat);
      chk({nm, "_rdata"}, ard, erd);
      chk({nm, "_acc_err"}, 32'(aerr), 32'(eerr));
      chk({nm, "_latency"}, 32'(alat), 32'(elat));
   endtask

   task automatic run_t(input string nm, input vec_t v);
      logic [31:0] erd, ard;
      logic        eerr, aerr;
      int          elat, alat;
      model(v.wr, v.sz, v.lt, v.a, v.wd, erd, eerr, elat);
      do_req(nm, v.wr, v.sz, v.lt, v.a, v.wd, ard, aerr, alat);
      chk({nm, "_rdata"}, ard, v.rd);
      chk({nm, "_acc_err"}, 32'(aerr), 32'(v.err));
      chk({nm, "_latency"}, 32'(alat), 32'(v.lat));
   endtask

   initial begin
      logic        r_wr;
      logic [1:0]  r_sz;
      logic [2:0]  r_lt;
      logic [31:0] r_a;
      int          seen;

      reset_n   = 1'b0;
      req_valid = 1'b0;
      d_wr_en   = 1'b0;
      d_size    = 2'b00;
      load_type = 3'b000;
      addr      = '0;
      wdata     = '0;
      repeat (3) @(negedge clk);
      chk("reset_req_ready", 32'(req_ready), 32'd1);
      chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("reset_rdata", rdata, 32'd0);
      chk("reset_acc_err", 32'(acc_err), 32'd0);
      reset_n = 1'b1;
      @(negedge clk);

      for (int w = 0; w < DEPTH; w++) run_m($sformatf("fill%0d", w), 1'b1, 2'b00, 3'b000, 32'(w * 4), $urandom);

      // {wr, size, type, addr, wdata, rdata, acc_err, latency}
      tbl.push_back('{1'b1, 2'b00, 3'b000, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1});
      tbl.push_back('{1'b0, 2'b00, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1});
      tbl.push_back('{1'b0, 2'b00, 3'b000, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0, 1});
      tbl.push_back('{1'b0, 2'b00, 3'b100, 32'h13, 32'h0, 32'h000000DE, 1'b0, 1});
      tbl.push_back('{1'b0, 2'b00, 3'b001, 32'h12, 32'h0, 32'hFFFFDEAD, 1'b0, 1});
      tbl.push_back('{1'b0, 2'b00, 3'b101, 32'h12, 32'h0, 32'h0000DEAD, 1'b0, 1});
      tbl.push_back('{1'b1, 2'b00, 3'b000, 32'h14, 32'h00000055, 32'h0, 1'b0, 1});
      tbl.push_back('{1'b0, 2'b00, 3'b010, 32'h11, 32'h0, SPLIT ? 32'h55DEADBE : 32'h0, !SPLIT, SPLIT ? 2 : 1});
      tbl.push_back('{1'b0, 2'b00, 3'b001, 32'h13, 32'h0, SPLIT ? 32'h000055DE : 32'h0, !SPLIT, SPLIT ? 2 : 1});
      tbl.push_back('{1'b1, 2'b10, 3'b000, 32'h11, 32'hAAAAAA77, 32'h0, 1'b0, 1});
      tbl.push_back('{1'b0, 2'b00, 3'b010, 32'h10, 32'h0, 32'hDEAD77EF, 1'b0, 1});
      tbl.push_back('{1'b0, 2'b00, 3'b001, 32'h11, 32'h0, 32'hFFFFAD77, 1'b0, 1});
      tbl.push_back('{1'b1, 2'b00, 3'b000, 32'h20, 32'h0, 32'h0, 1'b0, 1});
      tbl.push_back('{1'b1, 2'b01, 3'b000, 32'h22, 32'hFFFF1234, 32'h0, 1'b0, 1});
      tbl.push_back('{1'b0, 2'b00, 3'b010, 32'h20, 32'h0, 32'h12340000, 1'b0, 1});
      tbl.push_back('{1'b1, 2'b00, 3'b000, 32'h24, 32'h11223344, 32'h0, 1'b0, 1});
      tbl.push_back('{1'b1, 2'b00, 3'b000, 32'h28, 32'h55667788, 32'h0, 1'b0, 1});
      tbl.push_back('{1'b1, 2'b01, 3'b000, 32'h27, 32'h0000BEEF, 32'h0, !SPLIT, SPLIT ? 2 : 1});
      tbl.push_back('{1'b0, 2'b00, 3'b010, 32'h24, 32'h0, SPLIT ? 32'hEF223344 : 32'h11223344, 1'b0, 1});
      tbl.push_back('{1'b0, 2'b00, 3'b010, 32'h28, 32'h0, SPLIT ? 32'h556677BE : 32'h55667788, 1'b0, 1});
      tbl.push_back('{1'b1, 2'b11, 3'b000, 32'h10, 32'hFFFFFFFF, 32'h0, 1'b1, 1});
      tbl.push_back('{1'b0, 2'b00, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 1});
      tbl.push_back('{1'b0, 2'b00, 3'b110, 32'h10, 32'h0, 32'h0, 1'b1, 1});
      tbl.push_back('{1'b0, 2'b00, 3'b111, 32'h10, 32'h0, 32'h0, 1'b1, 1});
      tbl.push_back('{1'b0, 2'b00, 3'b010, 32'h10, 32'h0, 32'hDEAD77EF, 1'b0, 1});
      tbl.push_back('{1'b1, 2'b00, 3'b000, 32'h3FC, 32'h0, 32'h0, 1'b0, 1});
      tbl.push_back('{1'b1, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0, 1'b0, 1});
      tbl.push_back('{1'b1, 2'b00, 3'b000, 32'h3FE, 32'hCAFEF00D, 32'h0, !SPLIT, SPLIT ? 2 : 1});
      tbl.push_back('{1'b0, 2'b00, 3'b010, 32'h3FC, 32'h0, SPLIT ? 32'hF00D0000 : 32'h0, 1'b0, 1});
      tbl.push_back('{1'b0, 2'b00, 3'b010, 32'h0, 32'h0, SPLIT ? 32'h0000CAFE : 32'h0, 1'b0, 1});
      tbl.push_back('{1'b0, 2'b00, 3'b010, 32'hABCD0010, 32'h0, 32'hDEAD77EF, 1'b0, 1});
      tbl.push_back('{1'b0, 2'b00, 3'b100, 32'h00000411, 32'h0, 32'h00000077, 1'b0, 1});
      foreach (tbl[i]) run_t($sformatf("vec%0d", i), tbl[i]);

      // Reset asserted on the accept edge: nothing accepted, nothing written.
      req_valid = 1'b1;
      d_wr_en   = 1'b1;
      d_size    = 2'b00;
      load_type = 3'b000;
      addr      = 32'h40;
      wdata     = 32'h0BADF00D;
      reset_n   = 1'b0;
      @(negedge clk);
      chk("rstA_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rstA_req_ready", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      reset_n   = 1'b1;
      seen = 0;
      repeat (3) begin
         @(negedge clk);
         if (rsp_valid) seen++;
      end
      chk("rstA_no_rsp", 32'(seen), 32'd0);
      run_m("rstA_lw", 1'b0, 2'b00, 3'b010, 32'h40, 32'h0);

`ifdef MISALIGN_SPLIT_EN
      // Reset while the second beat of a split store is pending.
      req_valid = 1'b1;
      d_wr_en   = 1'b1;
      d_size    = 2'b00;
      addr      = 32'h51;
      wdata     = 32'hA1B2C3D4;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      addr      = $urandom;
      wdata     = $urandom;
      @(negedge clk);
      chk("rstB_beat1_rsp", 32'(rsp_valid), 32'd0);
      chk("rstB_beat1_ready", 32'(req_ready), 32'd0);
      reset_n = 1'b0;
      @(negedge clk);
      chk("rstB_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rstB_req_ready", 32'(req_ready), 32'd1);
      reset_n = 1'b1;
      seen = 0;
      repeat (3) begin
         @(negedge clk);
         if (rsp_valid) seen++;
      end
      chk("rstB_no_rsp", 32'(seen), 32'd0);
      chk("rstB_ready_after", 32'(req_ready), 32'd1);
      mem_m[32'h51] = 8'hD4;
      mem_m[32'h52] = 8'hC3;
      mem_m[32'h53] = 8'hB2;
      run_m("rstB_lw_hi", 1'b0, 2'b00, 3'b010, 32'h54, 32'h0);
      run_m("rstB_lw_lo", 1'b0, 2'b00, 3'b010, 32'h50, 32'h0);
`endif

      for (int i = 0; i < 1500; i++) begin
         r_wr = 1'($urandom_range(0, 1));
         r_sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
         r_lt = ($urandom_range(0, 9) == 0) ? 3'($urandom) : lt_legal[$urandom_range(0, 4)];
         r_a  = $urandom_range(0, 1) ? 32'($urandom_range(0, 127)) : $urandom;
         run_m($sformatf("rand%0d", i), r_wr, r_sz, r_lt, r_a, $urandom);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
